// File: rtl/timer_bank_if.sv
// Bus bundle for timer_bank: per-channel controls in, status out.
// The controller side uses the master modport, the timer bank uses the slave modport.
interface timer_bank_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 4
);
    logic                      tick_en;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       abort;
    logic [CHANNELS-1:0]       hold;
    logic [CHANNELS-1:0]       auto_reload;
    logic [CHANNELS*WIDTH-1:0] value;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS-1:0]       expired;
    logic                      expired_any;
    logic [CHANNELS*WIDTH-1:0] time_left;

    modport master (
        output tick_en, start, abort, hold, auto_reload, value,
        input  running, expired, expired_any, time_left
    );

    modport slave (
        input  tick_en, start, abort, hold, auto_reload, value,
        output running, expired, expired_any, time_left
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of independent down-counting tick timers with one-shot or auto-reload mode.
// Each channel is a two-state FSM; every output comes straight from a register.
module timer_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 4
) (
    input  logic         clk,
    input  logic         Reset_n,
    timer_bank_if.slave  bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state   [CHANNELS];
    logic [WIDTH-1:0]    r_count   [CHANNELS];
    logic [CHANNELS-1:0] r_auto;
    logic [CHANNELS-1:0] r_expired;
    logic                r_expired_any;

    state_t              w_state_nxt [CHANNELS];
    logic [WIDTH-1:0]    w_count_nxt [CHANNELS];
    logic [WIDTH-1:0]    w_value     [CHANNELS];
    logic [CHANNELS-1:0] w_auto_nxt;
    logic [CHANNELS-1:0] w_expired_nxt;
    logic [CHANNELS-1:0] w_running;
    logic [CHANNELS*WIDTH-1:0] w_time_left;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_value[i] = bus.value[i*WIDTH +: WIDTH];
        end
    end

    // Per-channel priority: abort, then start, then a counted tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every next-state signal gets a hold-current default first so no branch can infer a latch.
            w_state_nxt[i]   = r_state[i];
            w_count_nxt[i]   = r_count[i];
            w_auto_nxt[i]    = r_auto[i];
            w_expired_nxt[i] = 1'b0;

            if (bus.abort[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_count_nxt[i] = '0;
            end else if (bus.start[i]) begin
                if (w_value[i] == '0) begin
                    w_state_nxt[i]   = ST_IDLE;
                    w_count_nxt[i]   = '0;
                    w_expired_nxt[i] = 1'b1;
                end else begin
                    w_state_nxt[i] = ST_RUN;
                    w_count_nxt[i] = w_value[i];
                    w_auto_nxt[i]  = bus.auto_reload[i];
                end
            end else if (r_state[i] == ST_RUN && bus.tick_en && !bus.hold[i]) begin
                if (r_count[i] > WIDTH'(1)) begin
                    w_count_nxt[i] = r_count[i] - WIDTH'(1);
                end else begin
                    // Final tick: pulse and either reload from the live value or go idle.
                    w_expired_nxt[i] = 1'b1;
                    if (r_auto[i] && w_value[i] != '0) begin
                        w_count_nxt[i] = w_value[i];
                        w_auto_nxt[i]  = bus.auto_reload[i];
                    end else begin
                        w_state_nxt[i] = ST_IDLE;
                        w_count_nxt[i] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the per-channel arrays are only CHANNELS entries of control state, so they are reset like any register.
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_count[i] <= '0;
            end
            r_auto        <= '0;
            r_expired     <= '0;
            r_expired_any <= 1'b0;
        end else begin
            // NOTE: non-blocking so every channel updates from the same pre-edge values.
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_count[i] <= w_count_nxt[i];
            end
            r_auto        <= w_auto_nxt;
            r_expired     <= w_expired_nxt;
            r_expired_any <= |w_expired_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_running[i]                     = (r_state[i] == ST_RUN);
            w_time_left[i*WIDTH +: WIDTH]    = r_count[i];
        end
    end

    assign bus.running     = w_running;
    assign bus.expired     = r_expired;
    assign bus.expired_any = r_expired_any;
    assign bus.time_left   = w_time_left;
endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (3 channels, 4-bit counters).
module tb_timer_bank;
    localparam int CH = 3;
    localparam int W  = 4;

    logic clk;
    logic Reset_n;
    int   n_checks;
    int   n_errors;

    timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_tick();
        bus.tick_en = 1'b1;
        step();
        bus.tick_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [CH-1:0] m);
        bus.start = m;
        step();
        bus.start = '0;
    endtask

    function automatic logic [W-1:0] tl(input int ch);
        return bus.time_left[ch*W +: W];
    endfunction

    task automatic set_value(input int ch, input logic [W-1:0] v);
        bus.value[ch*W +: W] = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset_n         = 1'b0;
        bus.tick_en     = 1'b0;
        bus.start       = '0;
        bus.abort       = '0;
        bus.hold        = '0;
        bus.auto_reload = '0;
        bus.value       = '0;

        // 1: reset state, one-shot countdown of 5
        idle(2);
        check("rst_running", 32'(bus.running), 0);
        check("rst_expired", 32'(bus.expired), 0);
        check("rst_any", 32'(bus.expired_any), 0);
        check("rst_time_left", 32'(bus.time_left), 0);
        Reset_n = 1'b1;
        idle(1);
        set_value(0, 4'd5);
        pulse_start(3'b001);
        check("t1_running", 32'(bus.running[0]), 1);
        check("t1_load", 32'(tl(0)), 5);
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            check($sformatf("t1_tl_tick%0d", k), 32'(tl(0)), 32'(5 - k));
            check($sformatf("t1_exp_tick%0d", k), 32'(bus.expired[0]), (k == 5) ? 1 : 0);
            if (k == 5) begin
                check("t1_any", 32'(bus.expired_any), 1);
                check("t1_idle_after", 32'(bus.running[0]), 0);
                step();
                check("t1_pulse_width", 32'(bus.expired[0]), 0);
                check("t1_any_width", 32'(bus.expired_any), 0);
            end
            idle(3);
        end

        // 2: auto-reload with value 3 across 7 ticks
        set_value(1, 4'd3);
        bus.auto_reload = 3'b010;
        pulse_start(3'b010);
        for (int k = 1; k <= 7; k++) begin
            do_tick();
            check($sformatf("t2_exp_tick%0d", k), 32'(bus.expired[1]), (k == 3 || k == 6) ? 1 : 0);
            check($sformatf("t2_run_tick%0d", k), 32'(bus.running[1]), 1);
            idle(2);
        end
        check("t2_tl_after7", 32'(tl(1)), 2);
        bus.abort = 3'b010;
        step();
        bus.abort = '0;
        bus.auto_reload = '0;
        check("t2_abort_run", 32'(bus.running[1]), 0);
        check("t2_abort_tl", 32'(tl(1)), 0);

        // 3: start and tick on the same edge -- the tick is not counted
        set_value(0, 4'd2);
        bus.start   = 3'b001;
        bus.tick_en = 1'b1;
        step();
        bus.start   = '0;
        bus.tick_en = 1'b0;
        check("t3_tl_load", 32'(tl(0)), 2);
        idle(2);
        do_tick();
        check("t3_tl_tick1", 32'(tl(0)), 1);
        check("t3_exp_tick1", 32'(bus.expired[0]), 0);
        idle(2);
        do_tick();
        check("t3_exp_tick2", 32'(bus.expired[0]), 1);
        check("t3_run_after", 32'(bus.running[0]), 0);
        idle(2);

        // 4: hold freezes the count for 3 ticks
        set_value(2, 4'd4);
        pulse_start(3'b100);
        do_tick(); idle(1);
        do_tick(); idle(1);
        check("t4_tl_pre_hold", 32'(tl(2)), 2);
        bus.hold = 3'b100;
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check($sformatf("t4_hold_tl%0d", k), 32'(tl(2)), 2);
            check($sformatf("t4_hold_exp%0d", k), 32'(bus.expired[2]), 0);
            idle(1);
        end
        bus.hold = '0;
        do_tick();
        check("t4_tl_after_release", 32'(tl(2)), 1);
        check("t4_exp_early", 32'(bus.expired[2]), 0);
        idle(1);
        do_tick();
        check("t4_exp_last", 32'(bus.expired[2]), 1);
        check("t4_tl_end", 32'(tl(2)), 0);
        idle(2);

        // 5: abort beats start; zero-valued start expires without running
        set_value(0, 4'd5);
        pulse_start(3'b001);
        do_tick(); idle(1);
        do_tick(); idle(1);
        check("t5_tl_mid", 32'(tl(0)), 3);
        bus.abort = 3'b001;
        bus.start = 3'b001;
        step();
        bus.abort = '0;
        bus.start = '0;
        check("t5_abort_run", 32'(bus.running[0]), 0);
        check("t5_abort_tl", 32'(tl(0)), 0);
        check("t5_abort_exp", 32'(bus.expired[0]), 0);
        set_value(0, 4'd0);
        pulse_start(3'b001);
        check("t5_zero_exp", 32'(bus.expired[0]), 1);
        check("t5_zero_run", 32'(bus.running[0]), 0);
        check("t5_zero_tl", 32'(tl(0)), 0);
        step();
        check("t5_zero_pulse_width", 32'(bus.expired[0]), 0);

        // 6: async reset mid-count, then simultaneous expiry on all channels
        bus.value = {4'd5, 4'd5, 4'd5};
        pulse_start(3'b111);
        do_tick(); idle(1);
        do_tick();
        check("t6_tl_before_rst", 32'(bus.time_left), 32'({4'd3, 4'd3, 4'd3}));
        #2 Reset_n = 1'b0;
        #1;
        check("t6_rst_running", 32'(bus.running), 0);
        check("t6_rst_tl", 32'(bus.time_left), 0);
        check("t6_rst_exp", 32'(bus.expired), 0);
        @(negedge clk);
        Reset_n = 1'b1;
        step();
        check("t6_release_exp", 32'(bus.expired), 0);
        check("t6_release_run", 32'(bus.running), 0);
        bus.value = {4'd3, 4'd3, 4'd3};
        pulse_start(3'b111);
        do_tick(); idle(1);
        do_tick();
        check("t6_any_early", 32'(bus.expired_any), 0);
        idle(1);
        do_tick();
        check("t6_exp_all", 32'(bus.expired), 7);
        check("t6_any", 32'(bus.expired_any), 1);
        step();
        check("t6_any_once", 32'(bus.expired_any), 0);
        check("t6_run_end", 32'(bus.running), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
